instr_fetch: RTL

- Fetch stage of the single-cycle/pipelined ARM datapath; sits directly upstream of instr_mem.
- Owns the program counter and drives instr_mem read port (en, addr_in).
- Captures instr_mem dout, which has one-cycle synchronous read latency, and presents {instruction, PC} to decode with a valid/ready handshake.
- Handles decode back-pressure with a one-entry skid buffer, and handles branch redirects by squashing in-flight fetches.

---
 rtl/instr_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues reads to instr_mem and hands {instr, pc} to decode
// through an output register backed by a one-entry skid buffer. Optional: FETCH_PERF_CNT_EN.
module instr_fetch #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_dout,
    input  logic                   br_taken,
    input  logic [ADDR_WIDTH-1:0]  br_target,
    input  logic                   id_ready,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0]  if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    logic [ADDR_WIDTH-1:0]  pc_r;
    logic                   pending_r;
    logic [ADDR_WIDTH-1:0]  pending_pc_r;
    logic                   skid_valid_r;
    logic [INSTR_WIDTH-1:0] skid_instr_r;
    logic [ADDR_WIDTH-1:0]  skid_pc_r;
    logic                   issue_s;
    logic                   xfer_s;
    logic                   load_out_s;

    // Issue is withheld whenever the returning word could find nowhere to land.
    always_comb begin
        issue_s    = 1'b0;
        xfer_s     = if_valid & id_ready;
        load_out_s = ~if_valid | xfer_s;
        if (!rst && !br_taken && !skid_valid_r && !(pending_r && if_valid && !id_ready)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    assign mem_en   = issue_s;
    assign mem_addr = pc_r;

    // PC advance and in-flight read tracking; a redirect discards the outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_PC;
            pending_r    <= 1'b0;
            pending_pc_r <= {ADDR_WIDTH{1'b0}};
        end else if (br_taken) begin
            pc_r      <= br_target & ALIGN_MASK;
            pending_r <= 1'b0;
        end else begin
            pending_r <= issue_s;
            if (issue_s) begin
                pending_pc_r <= pc_r;
                pc_r         <= pc_r + PC_STEP;
            end
        end
    end

    // Output register and skid buffer; the skid entry is always older than the return word.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid     <= 1'b0;
            if_instr     <= {INSTR_WIDTH{1'b0}};
            if_pc        <= {ADDR_WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            skid_instr_r <= {INSTR_WIDTH{1'b0}};
            skid_pc_r    <= {ADDR_WIDTH{1'b0}};
        end else if (br_taken) begin
            if_valid     <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (pending_r) begin
            if (load_out_s) begin
                if_valid <= 1'b1;
                if (skid_valid_r) begin
                    if_instr     <= skid_instr_r;
                    if_pc        <= skid_pc_r;
                    skid_instr_r <= mem_dout;
                    skid_pc_r    <= pending_pc_r;
                end else begin
                    if_instr <= mem_dout;
                    if_pc    <= pending_pc_r;
                end
            end else begin
                skid_valid_r <= 1'b1;
                skid_instr_r <= mem_dout;
                skid_pc_r    <= pending_pc_r;
            end
        end else if (xfer_s) begin
            if (skid_valid_r) begin
                if_instr     <= skid_instr_r;
                if_pc        <= skid_pc_r;
                skid_valid_r <= 1'b0;
            end else begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Free-running transfer and stall counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (xfer_s) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (if_valid && !id_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
